addsub_serial: RTL

- Parametrised, digit-serial add/subtract unit; successor to the team's flat 8-bit combinational adder.
- Processes DIGIT bits per clock through a WIDTH-bit operand, trading latency for area.
- Uses a start/busy/done handshake so a sequencer or datapath controller can issue operations and collect registered results.
- Adds modes the flat adder lacks: subtraction, signed-overflow detection, and configurable width and digit size.

---
 rtl/addsub_serial.sv | 128 ++++++++++++
 1 files changed

// File: rtl/addsub_serial.sv
// addsub_serial -- digit-serial add/subtract unit with a start/busy/done
// handshake. Each RUN cycle adds DIGIT bits of the operands, so an operation
// takes NSTEP = WIDTH/DIGIT cycles after the accepting start edge.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  request an operation (accepted only in IDLE or DONE)
//   a, b   WIDTH-bit operands, captured on an accepted start
//   cin    carry-in for addition (ignored when sub=1)
//   sub    0: a+b+cin, 1: a-b (a + ~b + 1)
//   busy   high while the operation is running
//   done   one-cycle pulse, result valid
//   sum    registered result, held until the next completion
//   cout   final carry-out (subtract: 1 = no borrow)
//   ovf    two's-complement signed overflow
module addsub_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTEP = WIDTH / DIGIT;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  generate
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("addsub_serial: DIGIT must be >= 1 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] opa_reg, opb_reg, part_reg;
  logic             carry_reg;
  logic [CW-1:0]    step_reg;
  logic             amsb_reg, bmsb_reg;

  logic             accept;
  logic             last;
  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] part_next;

  assign accept = start && (state_reg == IDLE || state_reg == DONE);
  assign last   = (state_reg == RUN) && (step_reg == CW'(NSTEP - 1));

  // One digit of the ripple: low DIGIT bits of each operand plus carry.
  assign dsum = (DIGIT+1)'(opa_reg[DIGIT-1:0]) + (DIGIT+1)'(opb_reg[DIGIT-1:0])
              + (DIGIT+1)'(carry_reg);

  // New digit enters from the MSB side, so after NSTEP steps the first
  // (least significant) digit has reached bit 0.
  assign part_next = (part_reg >> DIGIT)
                   | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last)   state_next = DONE;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state_reg == RUN);
    done = (state_reg == DONE);
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_reg   <= '0;
      opb_reg   <= '0;
      part_reg  <= '0;
      carry_reg <= 1'b0;
      step_reg  <= '0;
      amsb_reg  <= 1'b0;
      bmsb_reg  <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (accept) begin
      opa_reg   <= a;
      opb_reg   <= sub ? ~b : b;
      carry_reg <= sub ? 1'b1 : cin;
      step_reg  <= '0;
      part_reg  <= '0;
      amsb_reg  <= a[WIDTH-1];
      bmsb_reg  <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
    end else if (state_reg == RUN) begin
      opa_reg   <= opa_reg >> DIGIT;
      opb_reg   <= opb_reg >> DIGIT;
      carry_reg <= dsum[DIGIT];
      part_reg  <= part_next;
      step_reg  <= step_reg + CW'(1);
      if (last) begin
        sum  <= part_next;
        cout <= dsum[DIGIT];
        // Overflow: operands agree in sign but the result does not.
        ovf  <= (amsb_reg == bmsb_reg) && (part_next[WIDTH-1] != amsb_reg);
      end
    end
  end

endmodule
